// File: rtl/alu_logic_pkg.sv
// Opcode constants shared by the ALU bitwise-logic datapath.
package alu_logic_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_NAND = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/bitwise_logic_core.sv
// Combinational opcode decode and per-bit logic function; also used by the
// non-pipelined ALU path.
module bitwise_logic_core
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = '0;
    unique case (op_i)
      OP_AND:  res_o = op1_i & op2_i;
      OP_NAND: res_o = ~(op1_i & op2_i);
      OP_OR:   res_o = op1_i | op2_i;
      OP_NOR:  res_o = ~(op1_i | op2_i);
      OP_XOR:  res_o = op1_i ^ op2_i;
      OP_XNOR: res_o = ~(op1_i ^ op2_i);
      OP_NOT:  res_o = ~op1_i;
      OP_PASS: res_o = op1_i;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage elastic valid/ready pipeline around bitwise_logic_core.
// Define BLU_FLAGS_EN to add registered all-zeros / all-ones result flags.
module bitwise_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef BLU_FLAGS_EN
  output logic [WIDTH-1:0] o_dat,
  output logic             o_zero,
  output logic             o_ones
`else
  output logic [WIDTH-1:0] o_dat
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_op1_q, s1_op1_d;
  logic [WIDTH-1:0] s1_op2_q, s1_op2_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_dat_q, s2_dat_d;
  logic [WIDTH-1:0] core_res;
  logic             s2_adv;
  logic             accept;

  bitwise_logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i  (s1_op_q),
    .op1_i (s1_op1_q),
    .op2_i (s1_op2_q),
    .res_o (core_res)
  );

  always_comb begin
    // No skid buffer: ready depends combinationally on downstream ready.
    s2_adv  = s1_valid_q && (!s2_valid_q || i_ready);
    o_ready = !s1_valid_q || s2_adv;
    accept  = i_valid && o_ready;

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_op1_d   = s1_op1_q;
    s1_op2_d   = s1_op2_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = i_op;
      s1_op1_d   = i_op1;
      s1_op2_d   = i_op2;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_dat_d   = s2_dat_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_dat_d   = core_res;
    end else if (i_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_op1_q   <= '0;
      s1_op2_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_dat_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_op1_q   <= s1_op1_d;
      s1_op2_q   <= s1_op2_d;
      s2_valid_q <= s2_valid_d;
      s2_dat_q   <= s2_dat_d;
    end
  end

  assign o_valid = s2_valid_q;
  assign o_dat   = s2_dat_q;

`ifdef BLU_FLAGS_EN
  logic s2_zero_q, s2_ones_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_zero_q <= 1'b0;
      s2_ones_q <= 1'b0;
    end else if (s2_adv) begin
      s2_zero_q <= (core_res == '0);
      s2_ones_q <= &core_res;
    end
  end

  assign o_zero = s2_zero_q;
  assign o_ones = s2_ones_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: directed steps plus random
// stress against a truth-table reference model and in-order scoreboard.
module tb_bitwise_logic_pipe;
  import alu_logic_pkg::*;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] MASK = '1;
  // Per-opcode 4-entry truth table indexed by {a_bit, b_bit}; opcode 0 in low nibble.
  localparam logic [31:0] TT = {4'b1100, 4'b0011, 4'b1001, 4'b0110,
                                4'b0001, 4'b1110, 4'b0111, 4'b1000};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_valid, o_ready, o_valid, i_ready;
  logic [OP_W-1:0] i_op;
  logic [W-1:0]    i_op1, i_op2, o_dat;
`ifdef BLU_FLAGS_EN
  logic            o_zero, o_ones;
`endif

  int              total = 0;
  int              bad = 0;
  int              n_acc = 0;
  logic [W-1:0]    exp_q[$];
  logic            hold_pend = 1'b0;
  logic [W-1:0]    hold_dat = '0;

  bitwise_logic_pipe #(
    .WIDTH (W)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_op1   (i_op1),
    .i_op2   (i_op2),
    .o_valid (o_valid),
    .i_ready (i_ready),
`ifdef BLU_FLAGS_EN
    .o_dat   (o_dat),
    .o_zero  (o_zero),
    .o_ones  (o_ones)
`else
    .o_dat   (o_dat)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [OP_W-1:0] op,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3:0]   t;
    logic [W-1:0] r;
    t = TT[32'(op) * 4 +: 4];
    for (int i = 0; i < int'(W); i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [OP_W-1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    i_valid = v;
    i_op    = op;
    i_op1   = a;
    i_op2   = b;
  endtask

  // Observe one cycle at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (hold_pend) chk("hold", o_dat, hold_dat);
    hold_pend = o_valid && !i_ready;
    hold_dat  = o_dat;
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious", o_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("dat", o_dat, e);
`ifdef BLU_FLAGS_EN
        chk("zero", o_zero, e == '0);
        chk("ones", o_ones, e == MASK);
`endif
      end
    end
    if (i_valid && o_ready) begin
      exp_q.push_back(model(i_op, i_op1, i_op2));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, '0);
    i_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("drained", 64'(exp_q.size()), 0);
    tick();
    tick();
  endtask

  initial begin
    int acc0;
    int cyc;
    rst_n   = 1'b0;
    i_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    #12;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_dat", o_dat, '0);
`ifdef BLU_FLAGS_EN
    chk("rst_zero", o_zero, 1'b0);
    chk("rst_ones", o_ones, 1'b0);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_ready", o_ready, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back stream with latency check.
    drive(1'b1, OP_AND, 8'hF0, 8'h3C);
    tick();
    chk("lat_early", o_valid, 1'b0);
    drive(1'b1, OP_XOR, 8'hFF, 8'h0F);
    tick();
    drive(1'b1, OP_NOT, 8'h5A, 8'h00);
    #3;
    chk("s0_valid", o_valid, 1'b1);
    chk("s0_dat", o_dat, 8'h30);
    tick();
    drive(1'b0, '0, '0, '0);
    #3;
    chk("s1_dat", o_dat, 8'hF0);
    tick();
    #3;
    chk("s2_dat", o_dat, 8'hA5);
    drain();

    // NAND of A and 6 in every nibble.
    drive(1'b1, OP_NAND, 8'hAA, 8'h66);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    #3;
    chk("nand_ad", o_dat, 8'hDD);
    drain();

    // Flag corner cases.
    drive(1'b1, OP_NAND, 8'hFF, 8'hFF);
    tick();
    drive(1'b1, OP_NOR, 8'h00, 8'h00);
    tick();
    drain();

    // Sweep every opcode across all nibble pairs, replicated to both nibbles.
    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          drive(1'b1, OP_W'(op), {a[3:0], a[3:0]}, {b[3:0], b[3:0]});
          tick();
        end
    drain();

    // Backpressure: only two slots.
    i_ready = 1'b0;
    acc0 = n_acc;
    drive(1'b1, OP_OR, 8'h12, 8'h40);
    tick();
    drive(1'b1, OP_XNOR, 8'h3C, 8'h0F);
    tick();
    drive(1'b1, OP_PASS, 8'h77, 8'h00);
    #1;
    chk("bp_ready", o_ready, 1'b0);
    tick();
    tick();
    tick();
    chk("bp_count", 64'(n_acc - acc0), 2);
    chk("bp_hold", o_dat, 8'h52);
    i_ready = 1'b1;
    #1;
    chk("bp_reready", o_ready, 1'b1);
    tick();
    drain();

    // Mid-operation reset with two transactions in flight.
    i_ready = 1'b0;
    drive(1'b1, OP_AND, 8'hFF, 8'h81);
    tick();
    drive(1'b1, OP_OR, 8'h0F, 8'hF0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", o_valid, 1'b0);
    chk("mr_dat", o_dat, '0);
    chk("mr_ready", o_ready, 1'b1);
    exp_q.delete();
    hold_pend = 1'b0;
    drive(1'b0, '0, '0, '0);
    i_ready = 1'b1;
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_stale", o_valid, 1'b0);
    end

    // Random stress with random valid/ready.
    acc0 = n_acc;
    cyc  = 0;
    while (n_acc - acc0 < 4000 && cyc < 30000) begin
      i_ready = ($urandom_range(0, 9) < 7);
      drive(1'($urandom_range(0, 1)), OP_W'($urandom_range(0, 7)),
            W'($urandom), W'($urandom));
      tick();
      cyc++;
    end
    chk("rand_count", 64'(n_acc - acc0 >= 4000), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
